// File: rtl/axi_pkg.sv
// axi_pkg: AXI3 encodings, the burst-bridge FSM states and the CBus request/response structs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// cbus_req_t.len is 4 bits wide, which is enough for the largest legal burst (16 beats).
// A bridge built with a smaller MAX_LEN uses only the low LW bits of len.
package axi_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } bridge_state_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;       // beats - 1
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_axi_beat_counter.sv
// cbus_axi_beat_counter: counts W/R beats of the burst in flight and flags the final one.
// Latency: count updates one cycle after inc; last_beat and wlast are combinational from count.
// Backpressure: none; the counter only advances when the parent signals a completed beat.
//
// Ports: clk, reset (sync, active-high), clear (held in IDLE), inc (one beat done),
//        wr_data (write data phase active), len (beats - 1), last_beat, wlast.
module cbus_axi_beat_counter #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic          wr_data,
  input  logic [LW-1:0] len,
  output logic          last_beat,
  output logic          wlast
);

  // One bit wider than len, so a legal burst never wraps the count.
  logic [LW:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last_beat = (count == {1'b0, len});
  assign wlast     = wr_data & last_beat;

endmodule

// File: rtl/cbus_axi_burst_bridge.sv
// cbus_axi_burst_bridge: CBus master to AXI3 master bridge with INCR bursts of up to MAX_LEN beats.
// Latency: address valid 1 cycle after creq.valid in IDLE; cresp.ready is combinational with R/W/B handshakes.
// Backpressure: AXI valids are held until their handshake; the CBus master holds creq until cresp.ready.
//
// Ports: clk, reset (sync, active-high); creq/cresp CBus side; ar*/r*/aw*/w*/b* AXI3 master channels;
//        err, a sticky non-OKAY response flag, exists only when CBUS_AXI_RESP_CHECK_EN is defined.
// Only one burst is in flight at a time. rid and bid are ignored.
module cbus_axi_burst_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID  = 4'h0,
  parameter int         MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  cbus_req_t   creq,
  output cbus_resp_t  cresp,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
`ifdef CBUS_AXI_RESP_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int LW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  bridge_state_t state, next_state;
  logic [31:0]   addr_q;
  logic [2:0]    size_q;
  logic [LW-1:0] len_q;
  logic          wr_q;
  logic          beat_inc;
  logic          last_beat;
  logic          unused_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      len_q  <= '0;
      wr_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && creq.valid) begin
        addr_q <= creq.addr;
        size_q <= creq.size;
        len_q  <= creq.len[LW-1:0];
        wr_q   <= creq.is_write;
      end
    end
  end

  always_comb begin
    next_state = state;
    arvalid    = 1'b0;
    awvalid    = 1'b0;
    rready     = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    beat_inc   = 1'b0;
    cresp      = '0;
    case (state)
      IDLE: begin
        if (creq.valid) next_state = ADDR;
      end
      ADDR: begin
        if (wr_q) begin
          awvalid = 1'b1;
          if (awready) next_state = DATA;
        end else begin
          arvalid = 1'b1;
          if (arready) next_state = DATA;
        end
      end
      DATA: begin
        if (wr_q) begin
          wvalid = 1'b1;
          if (wready) begin
            beat_inc = 1'b1;
            // The final write beat is acknowledged to the master by the B response.
            if (last_beat) next_state = RESP;
            else           cresp.ready = 1'b1;
          end
        end else begin
          rready = 1'b1;
          if (rvalid) begin
            beat_inc    = 1'b1;
            cresp.ready = 1'b1;
            cresp.data  = rdata;
            if (rlast) begin
              cresp.last = 1'b1;
              next_state = IDLE;
            end
          end
        end
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          cresp.ready = 1'b1;
          cresp.last  = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  cbus_axi_beat_counter #(.LW(LW)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == IDLE),
    .inc       (beat_inc),
    .wr_data   ((state == DATA) && wr_q),
    .len       (len_q),
    .last_beat (last_beat),
    .wlast     (wlast)
  );

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 4'(len_q);
  assign arsize  = size_q;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 4'(len_q);
  assign awsize  = size_q;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid     = AXI_ID;
  assign wdata   = creq.data;
  assign wstrb   = creq.strobe;

`ifdef CBUS_AXI_RESP_CHECK_EN
  // Sticky until reset; the transfer itself still completes normally.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((state == DATA && !wr_q && rvalid && rresp != AXI_RESP_OKAY) ||
                 (state == RESP && bvalid && bresp != AXI_RESP_OKAY)) begin
      err <= 1'b1;
    end
  end
`endif

  // IDs are ignored (single burst in flight); response codes matter only with the error check.
  assign unused_ok = ^{rid, bid, rresp, bresp, creq.len};

endmodule

// File: tb/tb_cbus_axi_burst_bridge.sv
module tb_cbus_axi_burst_bridge;
  import axi_pkg::*;

  localparam logic [3:0] ID = 4'h3;

  logic clk = 1'b0;
  logic reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, rid, bid, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;
`ifdef CBUS_AXI_RESP_CHECK_EN
  logic err;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cbus_axi_burst_bridge #(.AXI_ID(ID), .MAX_LEN(16)) dut (
    .clk(clk), .reset(reset), .creq(creq), .cresp(cresp),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef CBUS_AXI_RESP_CHECK_EN
    , .err(err)
`endif
  );

  // Handshake-related outputs packed for compact comparisons.
  function automatic logic [6:0] hs();
    return {arvalid, awvalid, rready, wvalid, bready, cresp.ready, cresp.last};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    creq.valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      total++;
      if (hs() !== 7'b0 || wlast !== 1'b0) begin
        bad++;
        $display("FAIL idle: hs=%b wlast=%b want 0", hs(), wlast);
      end
      tick();
    end
  endtask

  // Read burst: the bench acts as the AXI slave and checks every cycle against the burst rules.
  task automatic run_read(input logic [31:0] addr, input int len, input int ar_wait,
                          input int first_gap, input int gap, input logic [1:0] rr);
    logic [31:0] exp_q[$];
    int g;
    for (int i = 0; i <= len; i++) exp_q.push_back($urandom);
    creq.valid = 1'b1; creq.is_write = 1'b0; creq.size = 3'd2; creq.addr = addr;
    creq.len = 4'(len); creq.strobe = 4'hf; creq.data = '0;
    @(negedge clk);
    total++;
    if (hs() !== 7'b0) begin
      bad++; $display("FAIL rd_req_cycle: hs=%b want 0000000", hs());
    end
    tick();
    for (int c = 0; c <= ar_wait; c++) begin
      arready = (c == ar_wait);
      @(negedge clk);
      total++;
      if ({arvalid, awvalid, rready} !== 3'b100 || araddr !== addr || arlen !== 4'(len) ||
          arsize !== 3'd2 || arburst !== 2'b01 || {arlock, arcache, arprot} !== 9'b0 || arid !== ID) begin
        bad++;
        $display("FAIL rd_addr: v=%b addr=%h len=%h burst=%b id=%h want v=100 addr=%h len=%h burst=01 id=%h",
                 {arvalid, awvalid, rready}, araddr, arlen, arburst, arid, addr, 4'(len), ID);
      end
      tick();
    end
    arready = 1'b0;
    for (int i = 0; i <= len; i++) begin
      g = (i == 0) ? first_gap : gap;
      rvalid = 1'b0;
      for (int c = 0; c < g; c++) begin
        @(negedge clk);
        total++;
        if ({rready, cresp.ready, cresp.last, arvalid} !== 4'b1000) begin
          bad++; $display("FAIL rd_gap: rready/ready/last/arvalid=%b want 1000",
                          {rready, cresp.ready, cresp.last, arvalid});
        end
        tick();
      end
      rvalid = 1'b1; rdata = exp_q[i]; rlast = (i == len); rresp = rr; rid = ID;
      @(negedge clk);
      total++;
      if ({rready, cresp.ready, cresp.last} !== {2'b11, (i == len)} || cresp.data !== exp_q[i]) begin
        bad++;
        $display("FAIL rd_beat%0d: rready/ready/last=%b data=%h want %b data=%h", i,
                 {rready, cresp.ready, cresp.last}, cresp.data, {2'b11, (i == len)}, exp_q[i]);
      end
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    creq.valid = 1'b0;
  endtask

  // Write burst; abort_beat >= 0 asserts reset during that beat instead of completing it.
  task automatic run_write(input logic [31:0] addr, input int len, input logic [3:0] strb,
                           input int aw_wait, input int stall_beat, input int stall_cyc,
                           input int b_wait, input logic [1:0] br, input int abort_beat);
    logic [31:0] d;
    int ws;
    creq.valid = 1'b1; creq.is_write = 1'b1; creq.size = 3'd2; creq.addr = addr;
    creq.len = 4'(len); creq.strobe = strb; creq.data = '0;
    @(negedge clk);
    total++;
    if (hs() !== 7'b0) begin
      bad++; $display("FAIL wr_req_cycle: hs=%b want 0000000", hs());
    end
    tick();
    for (int c = 0; c <= aw_wait; c++) begin
      awready = (c == aw_wait);
      @(negedge clk);
      total++;
      if ({awvalid, arvalid, wvalid} !== 3'b100 || awaddr !== addr || awlen !== 4'(len) ||
          awsize !== 3'd2 || awburst !== 2'b01 || {awlock, awcache, awprot} !== 9'b0 || awid !== ID) begin
        bad++;
        $display("FAIL wr_addr: v=%b addr=%h len=%h burst=%b id=%h want v=100 addr=%h len=%h burst=01 id=%h",
                 {awvalid, arvalid, wvalid}, awaddr, awlen, awburst, awid, addr, 4'(len), ID);
      end
      tick();
    end
    awready = 1'b0;
    for (int i = 0; i <= len; i++) begin
      d = $urandom;
      creq.data = d;
      if (i == abort_beat) begin
        reset = 1'b1; wready = 1'b0;
        tick();
        reset = 1'b0; creq.valid = 1'b0;
        @(negedge clk);
        total++;
        if (hs() !== 7'b0 || wlast !== 1'b0 || dut.state !== IDLE || dut.u_cnt.count !== 5'd0) begin
          bad++; $display("FAIL wr_abort: hs=%b wlast=%b state=%0d count=%0d want all 0",
                          hs(), wlast, dut.state, dut.u_cnt.count);
        end
        tick();
        return;
      end
      ws = (i == stall_beat) ? stall_cyc : 0;
      wready = 1'b0;
      for (int c = 0; c < ws; c++) begin
        @(negedge clk);
        total++;
        if ({wvalid, cresp.ready, awvalid, bready} !== 4'b1000 || wdata !== d ||
            wstrb !== strb || wlast !== (i == len)) begin
          bad++; $display("FAIL wr_stall%0d: v/rdy/aw/b=%b wdata=%h wstrb=%b wlast=%b want 1000 %h %b %b", i,
                          {wvalid, cresp.ready, awvalid, bready}, wdata, wstrb, wlast, d, strb, (i == len));
        end
        tick();
      end
      wready = 1'b1;
      @(negedge clk);
      total++;
      if ({wvalid, cresp.ready, cresp.last} !== {1'b1, (i != len), 1'b0} || wdata !== d ||
          wstrb !== strb || wlast !== (i == len) || wid !== ID) begin
        bad++; $display("FAIL wr_beat%0d: v/rdy/last=%b wdata=%h wstrb=%b wlast=%b wid=%h want %b %h %b %b %h", i,
                        {wvalid, cresp.ready, cresp.last}, wdata, wstrb, wlast, wid,
                        {1'b1, (i != len), 1'b0}, d, strb, (i == len), ID);
      end
      tick();
      wready = 1'b0;
    end
    for (int c = 0; c <= b_wait; c++) begin
      bvalid = (c == b_wait); bresp = br; bid = ID;
      @(negedge clk);
      total++;
      if ({bready, wvalid, cresp.ready, cresp.last} !== {2'b10, bvalid, bvalid}) begin
        bad++; $display("FAIL wr_resp: b/w/rdy/last=%b want %b",
                        {bready, wvalid, cresp.ready, cresp.last}, {2'b10, bvalid, bvalid});
      end
      tick();
    end
    bvalid = 1'b0; bresp = 2'b00;
    creq.valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    creq = '0; creq.valid = 1'b1;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    tick(); tick();
    @(negedge clk);
    total++;
    if (hs() !== 7'b0 || cresp !== '0 || wlast !== 1'b0) begin
      bad++; $display("FAIL reset_hold: hs=%b cresp=%h wlast=%b want 0", hs(), cresp, wlast);
    end
    tick();
    reset = 1'b0; creq.valid = 1'b0;
    @(negedge clk);
    total++;
    if (hs() !== 7'b0 || cresp !== '0 || dut.state !== IDLE || dut.u_cnt.count !== 5'd0) begin
      bad++; $display("FAIL reset_state: hs=%b cresp=%h state=%0d count=%0d want 0",
                      hs(), cresp, dut.state, dut.u_cnt.count);
    end
`ifdef CBUS_AXI_RESP_CHECK_EN
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL reset_err: err=%b want 0", err);
    end
`endif
    tick();
  endtask

  task automatic test_single_read();
    run_read(32'h1FC0_0000, 0, 0, 2, 0, 2'b00);
    idle_cycles(1);
  endtask

  task automatic test_burst_read();
    run_read(32'h0000_1000, 3, 1, 0, 2, 2'b00);
    idle_cycles(2);
  endtask

  task automatic test_burst_write();
    run_write(32'h0000_2000, 3, 4'b0011, 1, 1, 2, 1, 2'b00, -1);
    idle_cycles(1);
    run_write(32'h0000_2100, 0, 4'b1111, 0, 0, 1, 0, 2'b00, -1);
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_burst();
    run_write(32'h0000_3000, 3, 4'hf, 0, 9, 0, 0, 2'b00, 1);
    run_read(32'h0000_3100, 1, 0, 1, 1, 2'b00);
    idle_cycles(1);
    run_write(32'h0000_3200, 3, 4'b1100, 0, 2, 1, 0, 2'b00, -1);
    idle_cycles(1);
  endtask

  task automatic test_err();
    run_write(32'h0000_4000, 1, 4'hf, 0, 9, 0, 1, 2'b10, -1);
    idle_cycles(1);
`ifdef CBUS_AXI_RESP_CHECK_EN
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_set_b: err=%b want 1", err);
    end
    tick();
`endif
    run_read(32'h0000_4100, 2, 0, 0, 1, 2'b00);
    run_write(32'h0000_4200, 0, 4'hf, 0, 9, 0, 0, 2'b00, -1);
    idle_cycles(1);
`ifdef CBUS_AXI_RESP_CHECK_EN
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_sticky: err=%b want 1", err);
    end
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_clear: err=%b want 0", err);
    end
    tick();
`endif
    run_read(32'h0000_4300, 2, 0, 0, 0, 2'b11);
    idle_cycles(1);
`ifdef CBUS_AXI_RESP_CHECK_EN
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_set_r: err=%b want 1", err);
    end
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
`endif
  endtask

  // Each call starts on the cycle right after the previous final handshake, with creq.valid
  // high, so its first address-valid cycle lands exactly two cycles after that handshake.
  task automatic test_back_to_back();
    run_read(32'h0000_5000, 0, 0, 0, 0, 2'b00);
    run_write(32'h0000_5100, 0, 4'b0101, 0, 9, 0, 0, 2'b00, -1);
    run_read(32'h0000_5200, 1, 0, 0, 0, 2'b00);
    run_write(32'h0000_5300, 2, 4'b1010, 0, 9, 0, 0, 2'b00, -1);
    idle_cycles(1);
  endtask

  task automatic test_random();
    int len;
    logic [31:0] a;
    for (int n = 0; n < 24; n++) begin
      len = $urandom_range(0, 15);
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1)
        run_write(a, len, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, len),
                  $urandom_range(0, 3), $urandom_range(0, 2), 2'b00, -1);
      else
        run_read(a, len, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 2'b00);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_read();
    test_burst_write();
    test_reset_mid_burst();
    test_err();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
